// File: rtl/pic_tmr0_wdt_prescaler.sv
// Timer-source block for the PIC16F54 core: T0CKI synchroniser with edge select,
// the shared 8-bit prescaler (steered to TMR0 or WDT by PSA) and the WDT base timer.
// Outputs tmr0_inc and wdtmr are registered single-cycle pulses.
module pic_tmr0_wdt_prescaler #(
    parameter int unsigned WDT_PERIOD = 18,
    parameter int unsigned WDT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] option_in,
    input  logic       t0cki,
    input  logic       wdt_en,
    input  logic       clrwdt,
    input  logic       tmr0_wr,
    output logic       tmr0_inc,
    output logic       wdtmr,
    output logic [7:0] presc_q
);

    localparam logic [WDT_W-1:0] WdtLast = WDT_W'(WDT_PERIOD - 1);

    logic             t0cs, t0se, psa;
    logic [2:0]       ps;
    logic             s1_q, s2_q, s3_q;
    logic             psa_q;
    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic [7:0]       presc_d;
    logic             tmr0_inc_d, wdtmr_d;

    logic             rise_evt, fall_evt, ext_evt, src_evt, wdt_evt;
    logic             psa_chg, presc_clr, presc_evt, presc_full, scaled_pulse;
    logic [7:0]       mask_tmr, mask_wdt, mask;

    // OPTION bits 7:6 are not used by the timer block
    logic unused_opt;
    assign unused_opt = ^option_in[7:6];

    // Event detection, WDT base next-state and prescaler steering
    always_comb begin
        t0cs = option_in[5];
        t0se = option_in[4];
        psa  = option_in[3];
        ps   = option_in[2:0];

        rise_evt = s2_q & ~s3_q;
        fall_evt = ~s2_q & s3_q;
        ext_evt  = t0se ? fall_evt : rise_evt;
        src_evt  = t0cs ? ext_evt : 1'b1;

        // clrwdt both restarts the base timer and swallows a coincident time-out
        wdt_evt = wdt_en & ~clrwdt & (wdt_cnt_q == WdtLast);
        if (!wdt_en || clrwdt) begin
            wdt_cnt_d = '0;
        end else if (wdt_cnt_q == WdtLast) begin
            wdt_cnt_d = '0;
        end else begin
            wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
        end

        // TMR0 ratio 1:2..1:256, WDT ratio 1:1..1:128
        mask_tmr = 8'hFF >> (3'd7 - ps);
        mask_wdt = mask_tmr >> 1;
        mask     = psa ? mask_wdt : mask_tmr;

        psa_chg    = psa ^ psa_q;
        presc_clr  = psa_chg | (psa ? clrwdt : tmr0_wr);
        presc_evt  = psa ? wdt_evt : src_evt;
        presc_full = (presc_q & mask) == mask;

        if (presc_clr) begin
            presc_d = 8'h00;
        end else if (presc_evt) begin
            presc_d = presc_q + 8'h01;
        end else begin
            presc_d = presc_q;
        end

        scaled_pulse = presc_evt & presc_full & ~presc_clr;

        // A PSA switch is a reassignment cycle: neither output may pulse
        tmr0_inc_d = psa ? (src_evt & ~psa_chg) : scaled_pulse;
        wdtmr_d    = psa ? scaled_pulse : (wdt_evt & ~psa_chg);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            psa_q     <= 1'b0;
            wdt_cnt_q <= '0;
            presc_q   <= 8'h00;
            tmr0_inc  <= 1'b0;
            wdtmr     <= 1'b0;
        end else begin
            s1_q      <= t0cki;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            psa_q     <= psa;
            wdt_cnt_q <= wdt_cnt_d;
            presc_q   <= presc_d;
            tmr0_inc  <= tmr0_inc_d;
            wdtmr     <= wdtmr_d;
        end
    end

endmodule
